// File: rtl/axis_ad77xx_chain_rx.sv
// axis_ad77xx_chain_rx: AD7763-family daisy-chain SDO deserialiser framing NUM_CHANNELS words onto AXI-Stream through a frame-atomic FIFO.
// Ports: aclk/aresetn (async active-low); enable gates new frames; clear zeroes overflow_count and frame_error;
// adc_dreadyn/adc_sdo ADC serial interface; m_axis_* stream (tuser = channel, tlast = last channel);
// overflow_count counts dropped frames (saturating); frame_error is sticky on a start seen mid-frame.
// Define STATUS_PASSTHRU_EN to emit the full raw word zero-extended instead of the sign-extended sample.
module axis_ad77xx_chain_rx #(
  parameter int NUM_CHANNELS    = 2,
  parameter int WORD_WIDTH      = 32,
  parameter int SAMPLE_WIDTH    = 24,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH      = 16,
  localparam int UW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       adc_dreadyn,
  input  logic                       adc_sdo,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [UW-1:0]              m_axis_tuser,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [15:0]                overflow_count,
  output logic                       frame_error
);
  localparam int BW = WORD_WIDTH > 1 ? $clog2(WORD_WIDTH) : 1;
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = AXIS_DATA_WIDTH + UW + 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic dreadyn_q, start, space_ok, go, drop, word_done, frame_done, wr_pend, pop;
  logic [BW-1:0] bit_cnt;
  logic [UW-1:0] ch_cnt;
  logic [WORD_WIDTH-2:0] shreg;
  logic [WORD_WIDTH-1:0] word_in;
  logic [AXIS_DATA_WIDTH-1:0] fmt;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, occ;
  assign start      = dreadyn_q & ~adc_dreadyn;
  assign word_in    = {shreg, adc_sdo};
  assign word_done  = state == SHIFT && bit_cnt == BW'(WORD_WIDTH - 1);
  assign frame_done = word_done && ch_cnt == UW'(NUM_CHANNELS - 1);
  // Occupancy counts the presented head and the word waiting to be written, so a
  // whole frame's worth of space is reserved before the first bit is shifted.
  assign occ      = cnt + CW'(m_axis_tvalid) + CW'(wr_pend);
  assign space_ok = CW'(FIFO_DEPTH) - occ >= CW'(NUM_CHANNELS);
  assign go       = state == IDLE && start && enable && space_ok;
  assign drop     = state == IDLE && start && enable && !space_ok;
  assign pop      = cnt != '0 && (!m_axis_tvalid || m_axis_tready);
`ifdef STATUS_PASSTHRU_EN
  assign fmt = AXIS_DATA_WIDTH'(word_in);
`else
  logic signed [SAMPLE_WIDTH-1:0] sample;
  assign sample = word_in[WORD_WIDTH-1 -: SAMPLE_WIDTH];
  assign fmt    = AXIS_DATA_WIDTH'(sample);
`endif
  always_comb state_n = go ? SHIFT : frame_done ? IDLE : state;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= IDLE;
      dreadyn_q      <= 1'b0;
      bit_cnt        <= '0;
      ch_cnt         <= '0;
      shreg          <= '0;
      wr_pend        <= 1'b0;
      wr_entry       <= '0;
      overflow_count <= '0;
      frame_error    <= 1'b0;
    end else begin
      state     <= state_n;
      dreadyn_q <= adc_dreadyn;
      wr_pend   <= word_done;
      if (go) begin
        bit_cnt <= '0;
        ch_cnt  <= '0;
      end else if (state == SHIFT) begin
        shreg   <= word_in[WORD_WIDTH-2:0];
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
        if (word_done) begin
          ch_cnt   <= ch_cnt + 1'b1;
          wr_entry <= {fmt, ch_cnt, ch_cnt == UW'(NUM_CHANNELS - 1)};
        end
      end
      if (clear) overflow_count <= '0;
      else if (drop && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 1'b1;
      if (clear) frame_error <= 1'b0;
      else if (state == SHIFT && start) frame_error <= 1'b1;
    end
  end
  always_ff @(posedge aclk) if (wr_pend) mem[wr_ptr] <= wr_entry;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (wr_pend) wr_ptr <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
        {m_axis_tdata, m_axis_tuser, m_axis_tlast} <= mem[rd_ptr];
      end
      m_axis_tvalid <= pop | (m_axis_tvalid & ~m_axis_tready);
      cnt           <= cnt + CW'(wr_pend) - CW'(pop);
    end
  end
endmodule

// File: doc/axis_ad77xx_chain_rx.md
Name: axis_ad77xx_chain_rx

Overview:
- Next-generation AD7763-family serial receiver on the ADC clock domain.
- Deserialises a daisy-chain of NUM_CHANNELS ADC words from one SDO line, frames them onto AXI-Stream (tuser = channel index, tlast = last channel), and buffers them in an internal FIFO.
- Frames are dropped atomically when the FIFO lacks space, and an overflow counter records each drop.
- Sits in place of the single-channel stream receiver inside the AXI/AXIS ADC wrapper.

Parameters:
- NUM_CHANNELS, 2, number of daisy-chained ADC words per frame (1..16).
- WORD_WIDTH, 32, bits per ADC word on SDO: sample MSBs followed by status LSBs.
- SAMPLE_WIDTH, 24, sample bits at the top of each word (SAMPLE_WIDTH <= WORD_WIDTH).
- AXIS_DATA_WIDTH, 32, stream data width (>= SAMPLE_WIDTH).
- FIFO_DEPTH, 16, FIFO entries; power of two; >= NUM_CHANNELS.

Ports:
- aclk  in  1  ADC serial clock; single clock for the whole block.
- aresetn  in  1  asynchronous, active-low reset.
- enable  in  1  when low, no new frame starts; a frame in progress completes.
- clear  in  1  one-cycle pulse that zeroes overflow_count and frame_error.
- adc_dreadyn  in  1  ADC data ready, active low.
- adc_sdo  in  1  ADC serial data, MSB first, sampled on rising aclk.
- m_axis_tdata  out  AXIS_DATA_WIDTH  sample.
- m_axis_tuser  out  max(1,clog2(NUM_CHANNELS))  channel index.
- m_axis_tlast  out  1  high on the channel NUM_CHANNELS-1 word.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- overflow_count  out  16  count of dropped frames; saturates at 0xFFFF.
- frame_error  out  1  sticky; set by a dreadyn falling edge seen while SHIFT.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, FIFO empty.
- Start detection: adc_dreadyn is registered once. A start is the registered value equal to 1 while the current value is 0.
- IDLE -> SHIFT on a start when enable=1 and FIFO free entries >= NUM_CHANNELS.
  - Otherwise the start is ignored.
  - If enable=1 but space is insufficient, overflow_count increments; no words from that frame enter the FIFO.
- SHIFT:
  - Bit counter 0..WORD_WIDTH-1; channel counter 0..NUM_CHANNELS-1.
  - The first data bit is sampled in the cycle after the start cycle.
  - Each cycle, adc_sdo is shifted in.
  - On bit WORD_WIDTH-1, the word is written to the FIFO on the next edge with tuser = channel and tlast = (channel == NUM_CHANNELS-1).
  - After the last channel, SHIFT -> IDLE.
  - A new start during SHIFT sets frame_error and does not restart the frame.
- A write cannot fail: space was reserved at frame start.
- tdata:
  - Default: sample field, sign-extended to AXIS_DATA_WIDTH.
  - Status bits are discarded unless STATUS_PASSTHRU_EN is defined.
- FIFO:
  - Registered output, first-word fall-through.
  - Latency: last bit sampled at edge N, FIFO write at N+1, tvalid at N+2 when the FIFO was empty.
  - Handshake: tvalid stays high and tdata/tuser/tlast stay stable until tvalid&tready.
  - A read and a write in the same cycle at full or empty keep the count correct.
  - Pointers wrap modulo FIFO_DEPTH.
- clear takes priority over a same-cycle overflow increment.
- Reset mid-frame discards the partial frame and FIFO contents; the next start after deassertion begins a clean frame.

Optional Feature:
- Macro: STATUS_PASSTHRU_EN.
- When defined: requires AXIS_DATA_WIDTH >= WORD_WIDTH. tdata = the full raw WORD_WIDTH word, zero-extended, so status bits reach software.
- When undefined: tdata = sign-extended sample only.
- Port list is identical either way.

Test Plan:
- NUM_CHANNELS=2; send words 0x7FFFFF_A5 then 0x800000_3C; tready=1 -> tdata 0x007FFFFF (tuser 0, tlast 0), then 0xFFFFFFFF800000 truncated to 0xFF800000 (tuser 1, tlast 1); tvalid two cycles after the last bit.
- Same frames with STATUS_PASSTHRU_EN defined -> tdata 0x7FFFFFA5 then 0x8000003C.
- tready=0; FIFO_DEPTH=16; send 9 frames -> 8 frames stored, overflow_count=1, FIFO count 16; release tready -> exactly 16 beats with tlast on every second beat, no partial frame.
- Start edge injected 10 cycles into SHIFT -> frame_error=1, current frame still completes with 2 beats; clear pulse -> frame_error=0, overflow_count=0.
- enable=0 on a start edge -> no beats, overflow_count unchanged; enable dropped mid-frame -> that frame completes.
- aresetn asserted mid-SHIFT with 3 entries queued -> tvalid=0 immediately; after release, next frame delivers exactly 2 correct beats.
